vote_recorder: RTL and testbench
================================

# vote_recorder

Input-side companion to the LED display controller of the voting machine. It qualifies the four candidate push-buttons and records one vote per qualified press into four saturating tallies. It also pulses `valid_vote_casted` for each accepted vote. Its `candidateN_vote` and `valid_vote_casted` outputs feed the display controller directly; `mode` is shared with it (0 = voting, 1 = results).

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive sampled cycles a single button must be high to count as a vote; legal range ≥ 2.
- `COUNT_WIDTH`, default 8: width of each tally.
- `clock`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `mode`  input  1  0 = voting enabled, 1 = results display (recording disabled).
- `candidate1_button` .. `candidate4_button`  input  1 each  raw button levels, synchronous to `clock`.
- `candidate1_vote` .. `candidate4_vote`  output  COUNT_WIDTH each  registered vote tallies.
- `valid_vote_casted`  output  1  registered; high for exactly one cycle per accepted vote.

## Operation
- On reset:
  - all tallies = 0;
  - `valid_vote_casted` = 0;
  - state = IDLE;
  - hold counter = 0;
  - latched candidate = 0.
- "Single press" means exactly one of the four buttons is high. "None pressed" means all four are low.
- State IDLE:
  - if `mode`==0 and single press: latch the candidate index, set hold counter = 1, go to DEBOUNCE;
  - otherwise stay in IDLE (0 or ≥2 buttons are ignored).
- State DEBOUNCE:
  - if `mode`==1, the latched button is low, or any other button is high: go to IDLE; no vote, no pulse;
  - else if hold counter == DEBOUNCE_CYCLES−1: increment the latched tally, assert `valid_vote_casted`, go to WAIT_RELEASE;
  - else: increment the hold counter.
- State WAIT_RELEASE: stay until none pressed, then go to IDLE. This gives one vote per press regardless of hold length. A `mode` change does not shorten this wait.
- Tallies saturate at 2^COUNT_WIDTH−1. An accepted vote on a saturated tally still pulses `valid_vote_casted` but leaves the value unchanged.
- Tallies are held unchanged while `mode`==1. Only `reset` clears them.
- `valid_vote_casted` is 0 in every cycle except the one following a commit edge.

## Timing
- Button high at sampled edges E0..E(D−1), where D = DEBOUNCE_CYCLES:
  - E0 moves the FSM IDLE→DEBOUNCE;
  - E(D−1) commits the vote.
  - The new tally and `valid_vote_casted`=1 are visible after E(D−1). The pulse deasserts after E(D).
- Minimum press length for a vote is D cycles. Back-to-back votes need at least one all-low sampled cycle between presses.
- Reset asserted mid-DEBOUNCE or mid-WAIT_RELEASE immediately forces all outputs and state to their reset values. After reset deasserts, a button already held is treated as a fresh press from IDLE.
- The hold counter is ceil(log2(DEBOUNCE_CYCLES)) bits wide and never wraps, because it is compared for equality before incrementing.

## Structure
- Shared package `vote_pkg` holds:
  - the FSM state enum `vote_state_t` (IDLE, DEBOUNCE, WAIT_RELEASE);
  - `NUM_CANDIDATES` = 4;
  - the candidate index type (2 bits).
- One sub-module, `sat_counter` (parameter WIDTH; ports: clock, reset, inc, count), instantiated four times, one per tally. Its `inc` is the one-hot commit strobe from the FSM.
- The FSM, hold counter, and single-press decode live in `vote_recorder`.

## Test plan
- Reset then idle, with D=4: all outputs 0 and stay 0 for 20 cycles with no buttons pressed.
- Button 2 high for 4 cycles in mode 0:
  - `candidate2_vote` = 1 and a single 1-cycle `valid_vote_casted` pulse after the 4th edge;
  - other tallies stay 0.
- Short and conflicting presses:
  - button 1 high for 3 cycles → no change, no pulse;
  - buttons 1 and 3 high together for 10 cycles → no change.
- Button 4 held for 50 cycles, released, then held for 4 more cycles: `candidate4_vote` = 2 and exactly two pulses.
- Mode and reset interaction:
  - `mode`=1, button 3 held for 10 cycles → no change;
  - return to `mode`=0 → tallies still hold prior values;
  - reset asserted mid-DEBOUNCE → all zeros immediately.
- Saturation, with COUNT_WIDTH=2: five valid presses of button 1 → `candidate1_vote` = 3 and five pulses.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types for the voting-machine input side: FSM states, candidate count
// and the candidate index type used by the vote recorder.
package vote_pkg;

  localparam int NUM_CANDIDATES = 4;

  typedef logic [1:0] cand_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    WAIT_RELEASE
  } vote_state_t;

  // Index of the set bit of a one-hot button vector; 0 when no bit is set.
  function automatic cand_idx_t onehot_idx(input logic [NUM_CANDIDATES-1:0] v);
    cand_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (v[i]) idx = cand_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vote_recorder_if.sv
// Button, mode and tally signals shared between the voting panel, the vote
// recorder and the LED display controller.
interface vote_recorder_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   mode;
  logic                   candidate1_button;
  logic                   candidate2_button;
  logic                   candidate3_button;
  logic                   candidate4_button;
  logic [COUNT_WIDTH-1:0] candidate1_vote;
  logic [COUNT_WIDTH-1:0] candidate2_vote;
  logic [COUNT_WIDTH-1:0] candidate3_vote;
  logic [COUNT_WIDTH-1:0] candidate4_vote;
  logic                   valid_vote_casted;

  modport master (
    output mode,
    output candidate1_button, candidate2_button, candidate3_button, candidate4_button,
    input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
    input  valid_vote_casted
  );

  modport slave (
    input  mode,
    input  candidate1_button, candidate2_button, candidate3_button, candidate4_button,
    output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
    output valid_vote_casted
  );
endinterface

// File: rtl/sat_counter.sv
// Single saturating vote tally: counts inc strobes, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/vote_recorder.sv
// Qualifies the four candidate buttons (single press held DEBOUNCE_CYCLES
// cycles) and records one vote per press into saturating tallies.
module vote_recorder
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_WIDTH     = 8
) (
  input logic            clock,
  input logic            reset,
  vote_recorder_if.slave bus
);

  localparam int HOLD_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DEBOUNCE_CYCLES - 1);

  vote_state_t               state, state_nxt;
  logic [HOLD_W-1:0]         hold, hold_nxt;
  cand_idx_t                 cand, cand_nxt;
  logic                      commit;
  logic                      valid;
  logic [NUM_CANDIDATES-1:0] buttons;
  logic [NUM_CANDIDATES-1:0] cand_mask;
  logic [NUM_CANDIDATES-1:0] inc;
  logic                      single_press;
  logic                      none_pressed;
  logic [COUNT_WIDTH-1:0]    tally [NUM_CANDIDATES];

  assign buttons      = {bus.candidate4_button, bus.candidate3_button,
                         bus.candidate2_button, bus.candidate1_button};
  assign single_press = $onehot(buttons);
  assign none_pressed = (buttons == '0);
  assign cand_mask    = NUM_CANDIDATES'(1) << cand;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
      cand  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      cand  <= cand_nxt;
      valid <= commit;
    end
  end

  // The hold counter is compared before incrementing, so it tops out at
  // DEBOUNCE_CYCLES-1 and never wraps.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    cand_nxt  = cand;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.mode && single_press) begin
          cand_nxt  = onehot_idx(buttons);
          hold_nxt  = HOLD_W'(1);
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (bus.mode || (buttons != cand_mask)) begin
          hold_nxt  = '0;
          state_nxt = IDLE;
        end else if (hold == HOLD_LAST) begin
          commit    = 1'b1;
          hold_nxt  = '0;
          state_nxt = WAIT_RELEASE;
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (none_pressed) state_nxt = IDLE;
      end
      default: begin
        hold_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    inc = '0;
    if (commit) inc[cand] = 1'b1;
  end

  for (genvar i = 0; i < NUM_CANDIDATES; i++) begin : g_tally
    sat_counter #(
      .WIDTH(COUNT_WIDTH)
    ) u_tally (
      .clock(clock),
      .reset(reset),
      .inc  (inc[i]),
      .count(tally[i])
    );
  end

  assign bus.candidate1_vote   = tally[0];
  assign bus.candidate2_vote   = tally[1];
  assign bus.candidate3_vote   = tally[2];
  assign bus.candidate4_vote   = tally[3];
  assign bus.valid_vote_casted = valid;

endmodule

// File: tb/tb_vote_recorder.sv
// Bench for vote_recorder: two instances (8-bit and 2-bit tallies, D=4) driven by
// directed and random button traffic, compared against a press-run model.
module tb_vote_recorder;

  localparam int D = 4;

  logic clk;
  logic rst;

  vote_recorder_if #(.COUNT_WIDTH(8)) ifa ();
  vote_recorder_if #(.COUNT_WIDTH(2)) ifb ();

  vote_recorder #(.DEBOUNCE_CYCLES(D), .COUNT_WIDTH(8)) dut_a (
    .clock(clk), .reset(rst), .bus(ifa)
  );
  vote_recorder #(.DEBOUNCE_CYCLES(D), .COUNT_WIDTH(2)) dut_b (
    .clock(clk), .reset(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a vote is a run of D consecutive edges with the same single button
  // in voting mode, started only after an all-released edge since the last vote.
  int maxv [2] = '{255, 3};
  int exp_tally [2][4];
  int exp_pulses [2];
  int obs_pulses [2];
  bit exp_valid [2];
  bit armed [2];
  int run [2];
  int cand [2];

  function automatic int tally_of(int u, int c);
    if (u == 0) begin
      case (c)
        0: return int'(ifa.candidate1_vote);
        1: return int'(ifa.candidate2_vote);
        2: return int'(ifa.candidate3_vote);
        default: return int'(ifa.candidate4_vote);
      endcase
    end else begin
      case (c)
        0: return int'(ifb.candidate1_vote);
        1: return int'(ifb.candidate2_vote);
        2: return int'(ifb.candidate3_vote);
        default: return int'(ifb.candidate4_vote);
      endcase
    end
  endfunction

  function automatic logic valid_of(int u);
    return (u == 0) ? ifa.valid_vote_casted : ifb.valid_vote_casted;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 4; c++) exp_tally[u][c] = 0;
      exp_valid[u] = 1'b0;
      armed[u] = 1'b1;
      run[u] = 0;
      cand[u] = 0;
    end
  endtask

  task automatic model_edge(int u, logic [3:0] b, logic m);
    int ones;
    int idx;
    ones = 0;
    idx = 0;
    for (int i = 0; i < 4; i++) if (b[i]) begin ones++; idx = i; end
    exp_valid[u] = 1'b0;
    if (!armed[u]) begin
      if (b == 4'b0) armed[u] = 1'b1;
    end else if (run[u] == 0) begin
      if (!m && ones == 1) begin
        run[u] = 1;
        cand[u] = idx;
      end
    end else if (m || ones != 1 || idx != cand[u]) begin
      run[u] = 0;
    end else begin
      run[u]++;
      if (run[u] == D) begin
        if (exp_tally[u][cand[u]] < maxv[u]) exp_tally[u][cand[u]]++;
        exp_valid[u] = 1'b1;
        exp_pulses[u]++;
        armed[u] = 1'b0;
        run[u] = 0;
      end
    end
  endtask

  task automatic drive(int u, logic [3:0] b, logic m);
    ifa.candidate1_button = (u == 0) ? b[0] : 1'b0;
    ifa.candidate2_button = (u == 0) ? b[1] : 1'b0;
    ifa.candidate3_button = (u == 0) ? b[2] : 1'b0;
    ifa.candidate4_button = (u == 0) ? b[3] : 1'b0;
    ifa.mode              = (u == 0) ? m : 1'b0;
    ifb.candidate1_button = (u == 1) ? b[0] : 1'b0;
    ifb.candidate2_button = (u == 1) ? b[1] : 1'b0;
    ifb.candidate3_button = (u == 1) ? b[2] : 1'b0;
    ifb.candidate4_button = (u == 1) ? b[3] : 1'b0;
    ifb.mode              = (u == 1) ? m : 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(int u, logic [3:0] b, logic m);
    drive(u, b, m);
    @(posedge clk);
    #1;
    model_edge(u, b, m);
    model_edge(1 - u, 4'b0, 1'b0);
    for (int k = 0; k < 2; k++) if (valid_of(k) === 1'b1) obs_pulses[k]++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 4'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (tally_of(u, c) !== 0) begin
          errors++;
          $display("FAIL reset_tally u%0d c%0d got %0d want 0", u, c + 1, tally_of(u, c));
        end
      end
      checks++;
      if (valid_of(u) !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid u%0d got %b want 0", u, valid_of(u));
      end
    end
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step(0, 4'b0, 1'b0);
      checks++;
      if (valid_of(0) !== 1'b0 || tally_of(0, 0) + tally_of(0, 1) + tally_of(0, 2) + tally_of(0, 3) != 0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d valid %b sum %0d want 0", n, valid_of(0),
                 tally_of(0, 0) + tally_of(0, 1) + tally_of(0, 2) + tally_of(0, 3));
      end
    end
  endtask

  task automatic test_single_vote();
    for (int n = 0; n < 3; n++) step(0, 4'b0010, 1'b0);
    checks++;
    if (valid_of(0) !== 1'b0 || tally_of(0, 1) != 0) begin
      errors++;
      $display("FAIL early_vote got valid %b tally %0d want 0 0", valid_of(0), tally_of(0, 1));
    end
    step(0, 4'b0010, 1'b0);
    checks++;
    if (valid_of(0) !== 1'b1 || tally_of(0, 1) != 1) begin
      errors++;
      $display("FAIL commit_edge got valid %b tally %0d want 1 1", valid_of(0), tally_of(0, 1));
    end
    step(0, 4'b0000, 1'b0);
    checks++;
    if (valid_of(0) !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width got valid %b want 0", valid_of(0));
    end
    checks++;
    if (tally_of(0, 0) != 0 || tally_of(0, 2) != 0 || tally_of(0, 3) != 0) begin
      errors++;
      $display("FAIL other_tallies got %0d %0d %0d want 0 0 0",
               tally_of(0, 0), tally_of(0, 2), tally_of(0, 3));
    end
  endtask

  task automatic test_short_conflict();
    int p0;
    p0 = obs_pulses[0];
    for (int n = 0; n < 3; n++) step(0, 4'b0001, 1'b0);
    step(0, 4'b0000, 1'b0);
    for (int n = 0; n < 10; n++) step(0, 4'b0101, 1'b0);
    step(0, 4'b0000, 1'b0);
    checks++;
    if (tally_of(0, 0) != 0 || tally_of(0, 2) != 0 || tally_of(0, 1) != 1) begin
      errors++;
      $display("FAIL short_conflict got c1 %0d c2 %0d c3 %0d want 0 1 0",
               tally_of(0, 0), tally_of(0, 1), tally_of(0, 2));
    end
    checks++;
    if (obs_pulses[0] != p0) begin
      errors++;
      $display("FAIL short_conflict_pulses got %0d want 0", obs_pulses[0] - p0);
    end
  endtask

  task automatic test_hold_long();
    int p0;
    p0 = obs_pulses[0];
    for (int n = 0; n < 50; n++) step(0, 4'b1000, 1'b0);
    step(0, 4'b0000, 1'b0);
    for (int n = 0; n < 4; n++) step(0, 4'b1000, 1'b0);
    step(0, 4'b0000, 1'b0);
    checks++;
    if (tally_of(0, 3) != 2) begin
      errors++;
      $display("FAIL hold_long_tally got %0d want 2", tally_of(0, 3));
    end
    checks++;
    if (obs_pulses[0] - p0 != 2) begin
      errors++;
      $display("FAIL hold_long_pulses got %0d want 2", obs_pulses[0] - p0);
    end
  endtask

  task automatic test_mode_reset();
    for (int n = 0; n < 10; n++) step(0, 4'b0100, 1'b1);
    step(0, 4'b0000, 1'b1);
    checks++;
    if (tally_of(0, 2) != 0 || valid_of(0) !== 1'b0) begin
      errors++;
      $display("FAIL results_mode got c3 %0d valid %b want 0 0", tally_of(0, 2), valid_of(0));
    end
    for (int n = 0; n < 3; n++) step(0, 4'b0000, 1'b0);
    checks++;
    if (tally_of(0, 1) != 1 || tally_of(0, 3) != 2) begin
      errors++;
      $display("FAIL mode_hold got c2 %0d c4 %0d want 1 2", tally_of(0, 1), tally_of(0, 3));
    end
    step(0, 4'b0001, 1'b0);
    step(0, 4'b0001, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tally_of(0, 1) != 0 || tally_of(0, 3) != 0 || valid_of(0) !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got c2 %0d c4 %0d valid %b want 0 0 0",
               tally_of(0, 1), tally_of(0, 3), valid_of(0));
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) step(0, 4'b0001, 1'b0);
    checks++;
    if (tally_of(0, 0) != 1 || valid_of(0) !== 1'b1) begin
      errors++;
      $display("FAIL fresh_after_reset got c1 %0d valid %b want 1 1", tally_of(0, 0), valid_of(0));
    end
    step(0, 4'b0000, 1'b0);
  endtask

  task automatic test_saturation();
    int p0;
    p0 = obs_pulses[1];
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 4; n++) step(1, 4'b0001, 1'b0);
      step(1, 4'b0000, 1'b0);
    end
    checks++;
    if (tally_of(1, 0) != 3) begin
      errors++;
      $display("FAIL saturation_tally got %0d want 3", tally_of(1, 0));
    end
    checks++;
    if (obs_pulses[1] - p0 != 5) begin
      errors++;
      $display("FAIL saturation_pulses got %0d want 5", obs_pulses[1] - p0);
    end
  endtask

  task automatic test_random();
    int u;
    int r;
    int len;
    logic [3:0] b;
    logic m;
    for (int seg = 0; seg < 80; seg++) begin
      u = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 6) b = 4'b0001 << $urandom_range(0, 3);
      else if (r < 8) b = 4'b0000;
      else b = 4'($urandom_range(0, 15));
      m = ($urandom_range(0, 5) == 0);
      len = int'($urandom_range(1, 7));
      for (int n = 0; n < len; n++) begin
        step(u, b, m);
        checks++;
        if (valid_of(u) !== exp_valid[u]) begin
          errors++;
          $display("FAIL rand_valid seg %0d u%0d got %b want %b", seg, u, valid_of(u), exp_valid[u]);
        end
        for (int c = 0; c < 4; c++) begin
          checks++;
          if (tally_of(u, c) != exp_tally[u][c]) begin
            errors++;
            $display("FAIL rand_tally seg %0d u%0d c%0d got %0d want %0d",
                     seg, u, c + 1, tally_of(u, c), exp_tally[u][c]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_pulses[k] != exp_pulses[k]) begin
        errors++;
        $display("FAIL rand_pulse_total u%0d got %0d want %0d", k, obs_pulses[k], exp_pulses[k]);
      end
    end
  endtask

  initial begin
    exp_pulses = '{0, 0};
    obs_pulses = '{0, 0};
    test_reset();
    test_single_vote();
    test_short_conflict();
    test_hold_long();
    test_mode_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
